ice_motor_link_responder: RTL

- Motor-board end of the host↔motor-board UART link. The host-side control block acts as initiator; this block is the responder.
- Sits on each iCE40 motor board between a byte-level UART and the local motor controller.
- Parses command frames into setpoint and control mode.
- Answers each command addressed to it with a status frame carrying encoder position, encoder velocity and current.
- Runs a link watchdog that disables the motor when commands stop arriving.

---
 rtl/ice_motor_link_responder_pkg.sv | 29 ++
 rtl/ice_motor_link_responder_if.sv | 24 ++
 rtl/ice_motor_link_responder_crc8_update.sv | 23 ++
 rtl/ice_motor_link_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ice_motor_link_responder_pkg.sv
// ice_link_pkg: shared constants and state encodings for the motor-board
// link responder.
//   SYNC_CMD / SYNC_STATUS : first byte of command / status frames
//   BROADCAST_ID           : address accepted by every board, never answered
//   CMD_LEN / STATUS_LEN   : frame lengths in bytes
//   CRC8_POLY              : CRC-8 polynomial (init 0, no reflection/xorout)
package ice_link_pkg;

    localparam logic [7:0]  SYNC_CMD     = 8'hA5;
    localparam logic [7:0]  SYNC_STATUS  = 8'h5A;
    localparam logic [7:0]  BROADCAST_ID = 8'hFF;
    localparam int unsigned CMD_LEN      = 8;
    localparam int unsigned STATUS_LEN   = 15;
    localparam logic [7:0]  CRC8_POLY    = 8'h07;

    typedef enum logic [2:0] {
        P_HUNT,
        P_ID,
        P_MODE,
        P_SP,
        P_CRC
    } rx_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_e;

endpackage

// File: rtl/ice_motor_link_responder_if.sv
// Byte-stream link between the UART and the responder.
//   rx_data/rx_valid : received byte and its one-cycle strobe
//   tx_data/tx_valid : byte offered to the transmitter, held until accepted
//   tx_ready         : transmitter can accept a byte
// master = UART side, slave = responder side.
interface ice_motor_link_responder_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid
    );

endinterface

// File: rtl/ice_motor_link_responder_crc8_update.sv
// crc8_update: combinational CRC-8 step over one byte (MSB first).
//   crc_in  : running CRC before this byte
//   data_in : byte to fold in
//   crc_out : running CRC after this byte
module crc8_update
    import ice_link_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] crc_c;

    always_comb begin
        crc_c = crc_in ^ data_in;
        for (int unsigned i = 0; i < 8; i++) begin
            crc_c = crc_c[7] ? ((crc_c << 1) ^ CRC8_POLY) : (crc_c << 1);
        end
        crc_out = crc_c;
    end

endmodule

// File: rtl/ice_motor_link_responder.sv
// ice_motor_link_responder: motor-board end of the host link.
//   clk, reset_n     : clock, synchronous active-low reset
//   link (slave)     : rx byte stream in, tx byte stream out
//   board_id         : this board's address
//   enc_position/enc_velocity/current : values reported in status frames
//   setpoint, control_mode : fields of the last accepted command
//   cmd_strobe       : one-cycle pulse per accepted command
//   crc_error_count  : saturating count of bad-CRC command frames
//   link_timeout     : no accepted command for WATCHDOG_CYCLES cycles
module ice_motor_link_responder
    import ice_link_pkg::*;
#(
    parameter int unsigned BYTE_TIMEOUT    = 5000,
    parameter int unsigned WATCHDOG_CYCLES = 5_000_000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    ice_motor_link_responder_if.slave  link,
    input  logic [7:0]                 board_id,
    input  logic signed [31:0]         enc_position,
    input  logic signed [31:0]         enc_velocity,
    input  logic signed [31:0]         current,
    output logic signed [31:0]         setpoint,
    output logic [7:0]                 control_mode,
    output logic                       cmd_strobe,
    output logic [15:0]                crc_error_count,
    output logic                       link_timeout
);

    // Parser state
    rx_state_e   rx_state_q, rx_state_d;
    logic [7:0]  rx_id_q, rx_id_d;
    logic [7:0]  rx_mode_q, rx_mode_d;
    logic [31:0] rx_sp_q, rx_sp_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic [7:0]  rx_crc_q, rx_crc_d;
    logic [31:0] byte_tmr_q, byte_tmr_d;

    // Command outputs and watchdog
    logic [31:0] setpoint_q, setpoint_d;
    logic [7:0]  mode_q, mode_d;
    logic        strobe_q, strobe_d;
    logic [15:0] crc_err_q, crc_err_d;
    logic        lt_q, lt_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] wd_inc;

    // Transmitter state and snapshot
    tx_state_e   tx_state_q, tx_state_d;
    logic [3:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_crc_q, tx_crc_d;
    logic [7:0]  snap_id_q, snap_id_d;
    logic [31:0] snap_pos_q, snap_pos_d;
    logic [31:0] snap_vel_q, snap_vel_d;
    logic [31:0] snap_cur_q, snap_cur_d;

    logic [7:0]  rx_crc_next;
    logic [7:0]  tx_crc_next;
    logic [7:0]  tx_byte;
    logic        accept;
    logic        respond;
    logic        crc_bad;

    crc8_update u_rx_crc (
        .crc_in  (rx_crc_q),
        .data_in (link.rx_data),
        .crc_out (rx_crc_next)
    );

    crc8_update u_tx_crc (
        .crc_in  (tx_crc_q),
        .data_in (tx_byte),
        .crc_out (tx_crc_next)
    );

    // Parser: a byte arrival always takes priority over the silence timer.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_id_d    = rx_id_q;
        rx_mode_d  = rx_mode_q;
        rx_sp_d    = rx_sp_q;
        rx_cnt_d   = rx_cnt_q;
        rx_crc_d   = rx_crc_q;
        byte_tmr_d = byte_tmr_q;
        accept     = 1'b0;
        respond    = 1'b0;
        crc_bad    = 1'b0;

        if (link.rx_valid) begin
            byte_tmr_d = '0;
            case (rx_state_q)
                P_HUNT: begin
                    if (link.rx_data == SYNC_CMD) begin
                        rx_state_d = P_ID;
                        rx_crc_d   = '0;
                    end
                end
                P_ID: begin
                    rx_id_d    = link.rx_data;
                    rx_crc_d   = rx_crc_next;
                    rx_state_d = P_MODE;
                end
                P_MODE: begin
                    rx_mode_d  = link.rx_data;
                    rx_crc_d   = rx_crc_next;
                    rx_cnt_d   = '0;
                    rx_state_d = P_SP;
                end
                P_SP: begin
                    rx_sp_d  = {rx_sp_q[23:0], link.rx_data};
                    rx_crc_d = rx_crc_next;
                    rx_cnt_d = rx_cnt_q + 3'd1;
                    if (rx_cnt_q == 3'd3) begin
                        rx_state_d = P_CRC;
                    end
                end
                P_CRC: begin
                    rx_state_d = P_HUNT;
                    if (link.rx_data == rx_crc_q) begin
                        if (rx_id_q == board_id) begin
                            accept  = 1'b1;
                            respond = 1'b1;
                        end else if (rx_id_q == BROADCAST_ID) begin
                            accept = 1'b1;
                        end
                    end else begin
                        crc_bad = 1'b1;
                    end
                end
                default: rx_state_d = P_HUNT;
            endcase
        end else if (rx_state_q != P_HUNT) begin
            if (byte_tmr_q >= BYTE_TIMEOUT) begin
                rx_state_d = P_HUNT;
                byte_tmr_d = '0;
            end else begin
                byte_tmr_d = byte_tmr_q + 32'd1;
            end
        end
    end

    // Command latch, error counter, watchdog
    always_comb begin
        setpoint_d = setpoint_q;
        mode_d     = mode_q;
        strobe_d   = accept;
        crc_err_d  = crc_err_q;
        lt_d       = lt_q;
        wd_d       = wd_q;
        wd_inc     = wd_q + 32'd1;

        if (crc_bad && crc_err_q != 16'hFFFF) begin
            crc_err_d = crc_err_q + 16'd1;
        end

        if (accept) begin
            setpoint_d = rx_sp_q;
            mode_d     = rx_mode_q;
            lt_d       = 1'b0;
            wd_d       = '0;
        end else if (WATCHDOG_CYCLES != 0 && !lt_q) begin
            wd_d = wd_inc;
            if (wd_inc == WATCHDOG_CYCLES) begin
                lt_d   = 1'b1;
                mode_d = '0;
            end
        end
    end

    // Status byte selection from the snapshot taken at accept time
    always_comb begin
        tx_byte = '0;
        case (tx_idx_q)
            4'd0:    tx_byte = SYNC_STATUS;
            4'd1:    tx_byte = snap_id_q;
            4'd2:    tx_byte = snap_pos_q[31:24];
            4'd3:    tx_byte = snap_pos_q[23:16];
            4'd4:    tx_byte = snap_pos_q[15:8];
            4'd5:    tx_byte = snap_pos_q[7:0];
            4'd6:    tx_byte = snap_vel_q[31:24];
            4'd7:    tx_byte = snap_vel_q[23:16];
            4'd8:    tx_byte = snap_vel_q[15:8];
            4'd9:    tx_byte = snap_vel_q[7:0];
            4'd10:   tx_byte = snap_cur_q[31:24];
            4'd11:   tx_byte = snap_cur_q[23:16];
            4'd12:   tx_byte = snap_cur_q[15:8];
            4'd13:   tx_byte = snap_cur_q[7:0];
            4'd14:   tx_byte = tx_crc_q;
            default: tx_byte = '0;
        endcase
    end

    // Transmitter: a command accepted mid-response does not restart it.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_idx_d   = tx_idx_q;
        tx_crc_d   = tx_crc_q;
        snap_id_d  = snap_id_q;
        snap_pos_d = snap_pos_q;
        snap_vel_d = snap_vel_q;
        snap_cur_d = snap_cur_q;

        case (tx_state_q)
            TX_IDLE: begin
                if (respond) begin
                    tx_state_d = TX_SEND;
                    tx_idx_d   = '0;
                    tx_crc_d   = '0;
                    snap_id_d  = rx_id_q;
                    snap_pos_d = enc_position;
                    snap_vel_d = enc_velocity;
                    snap_cur_d = current;
                end
            end
            TX_SEND: begin
                if (link.tx_ready) begin
                    if (tx_idx_q != 4'd0 && tx_idx_q != 4'(STATUS_LEN - 1)) begin
                        tx_crc_d = tx_crc_next;
                    end
                    if (tx_idx_q == 4'(STATUS_LEN - 1)) begin
                        tx_state_d = TX_IDLE;
                        tx_idx_d   = '0;
                    end else begin
                        tx_idx_d = tx_idx_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state_q <= P_HUNT;
            rx_id_q    <= '0;
            rx_mode_q  <= '0;
            rx_sp_q    <= '0;
            rx_cnt_q   <= '0;
            rx_crc_q   <= '0;
            byte_tmr_q <= '0;
            setpoint_q <= '0;
            mode_q     <= '0;
            strobe_q   <= 1'b0;
            crc_err_q  <= '0;
            lt_q       <= 1'b0;
            wd_q       <= '0;
            tx_state_q <= TX_IDLE;
            tx_idx_q   <= '0;
            tx_crc_q   <= '0;
            snap_id_q  <= '0;
            snap_pos_q <= '0;
            snap_vel_q <= '0;
            snap_cur_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_id_q    <= rx_id_d;
            rx_mode_q  <= rx_mode_d;
            rx_sp_q    <= rx_sp_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_crc_q   <= rx_crc_d;
            byte_tmr_q <= byte_tmr_d;
            setpoint_q <= setpoint_d;
            mode_q     <= mode_d;
            strobe_q   <= strobe_d;
            crc_err_q  <= crc_err_d;
            lt_q       <= lt_d;
            wd_q       <= wd_d;
            tx_state_q <= tx_state_d;
            tx_idx_q   <= tx_idx_d;
            tx_crc_q   <= tx_crc_d;
            snap_id_q  <= snap_id_d;
            snap_pos_q <= snap_pos_d;
            snap_vel_q <= snap_vel_d;
            snap_cur_q <= snap_cur_d;
        end
    end

    assign link.tx_valid   = (tx_state_q == TX_SEND);
    assign link.tx_data    = tx_byte;
    assign setpoint        = setpoint_q;
    assign control_mode    = mode_q;
    assign cmd_strobe      = strobe_q;
    assign crc_error_count = crc_err_q;
    assign link_timeout    = lt_q;

endmodule
